// File: rtl/data_bank_mp_pkg.sv
// kf_mem_pkg: shared defaults, clear-FSM encoding and address-width check for the KF data bank.
package kf_mem_pkg;
    localparam int KF_W     = 24;
    localparam int KF_DEPTH = 40;
    localparam int KF_ADDRW = 6;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } kf_state_e;

    function automatic int kf_clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1)
            r++;
        return r;
    endfunction
endpackage

// File: rtl/data_bank_mp_clear_seq.sv
// db_clear_seq: clear sweep FSM; zeroes one entry per cycle, auto-runs after reset.
module db_clear_seq
    import kf_mem_pkg::*;
#(
    parameter int DEPTH = KF_DEPTH,
    parameter int ADDRW = KF_ADDRW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_req,
    output logic             busy,
    output logic             clr_we,
    output logic [ADDRW-1:0] clr_addr
);
    localparam logic [ADDRW-1:0] LAST = ADDRW'(DEPTH - 1);

    kf_state_e        state;
    logic [ADDRW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
        end else if (state == ST_CLEAR) begin
            state <= cnt == LAST ? ST_IDLE : ST_CLEAR;
            cnt   <= cnt == LAST ? '0 : cnt + 1'b1;
            busy  <= cnt != LAST;
        end else if (clr_req) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
        end
    end

    assign clr_we   = busy;
    assign clr_addr = cnt;
endmodule

// File: rtl/data_bank_mp.sv
// data_bank_mp: KF flop register file, NRD read ports, one handshaked write port, valid scoreboard and clear sweep.
// Optional even parity per entry with rd_perr output when DB_PARITY_EN is defined.
module data_bank_mp
    import kf_mem_pkg::*;
#(
    parameter int W       = KF_W,
    parameter int DEPTH   = KF_DEPTH,
    parameter int ADDRW   = KF_ADDRW,
    parameter int NRD     = 2,
    parameter int RD_LAT  = 0,
    parameter int FORWARD = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_req,
    output logic               busy,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [ADDRW-1:0]   wr_addr,
    input  logic [W-1:0]       wr_data,
    input  logic [NRD*ADDRW-1:0] rd_addr,
    output logic [NRD*W-1:0]   rd_data,
    output logic [NRD-1:0]     rd_hit,
    output logic               addr_err,
`ifdef DB_PARITY_EN
    output logic [NRD-1:0]     rd_perr,
`endif
    input  logic               err_clr
);
`ifdef DB_PARITY_EN
    localparam int MW = W + 1;
`else
    localparam int MW = W;
`endif
    localparam logic [ADDRW:0] LIM = (ADDRW+1)'(DEPTH);

    if (kf_clog2(DEPTH) > ADDRW || NRD < 1 || NRD > 4 || RD_LAT < 0 || RD_LAT > 1) begin : g_bad_cfg
        $error("data_bank_mp: illegal parameter combination");
    end

    logic             clr_we;
    logic [ADDRW-1:0] clr_addr;
    logic             wr_acc;
    logic             wr_ok;
    logic             err_set;
    logic [MW-1:0]    wr_word;
    logic [MW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [NRD-1:0]   rd_oor;
    logic [NRD-1:0]   perr_c;

    db_clear_seq #(.DEPTH(DEPTH), .ADDRW(ADDRW)) u_clr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign wr_ready = !busy;
    assign wr_acc   = wr_valid && !busy;
    assign wr_ok    = wr_acc && ({1'b0, wr_addr} < LIM);
`ifdef DB_PARITY_EN
    assign wr_word  = {^wr_data, wr_data};
`else
    assign wr_word  = wr_data;
`endif

    always_ff @(posedge clk) begin
        if (clr_we)
            mem[clr_addr] <= '0;
        else if (wr_ok)
            mem[wr_addr] <= wr_word;
    end

    // A clear request wins over a same-cycle write for the valid bit; the sweep zeroes the data anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            valid <= '0;
        else if (busy || clr_req)
            valid <= '0;
        else if (wr_ok)
            valid[wr_addr] <= 1'b1;
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDRW-1:0] a;
        logic             ok;
        logic             fwd;
        logic             hit;
        logic [MW-1:0]    word;
        logic [W-1:0]     data;
        logic [W-1:0]     od;
        logic             oh;
        assign a    = rd_addr[i*ADDRW +: ADDRW];
        assign ok   = {1'b0, a} < LIM;
        assign fwd  = FORWARD != 0 && wr_ok && wr_addr == a;
        assign word = ok ? mem[a] : '0;
        assign data = fwd ? wr_data : word[W-1:0];
        assign hit  = ok && !busy && (fwd || valid[a]);
        assign rd_oor[i] = !ok;
`ifdef DB_PARITY_EN
        logic op;
        // Entries not yet swept hold arbitrary flop content, so parity is only trusted outside a sweep.
        assign perr_c[i] = ok && !busy && !fwd && ^word;
        assign rd_perr[i] = op;
`else
        assign perr_c[i] = 1'b0;
`endif
        if (RD_LAT == 0) begin : g_comb
            assign od = data;
            assign oh = hit;
`ifdef DB_PARITY_EN
            assign op = perr_c[i];
`endif
        end else begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    od <= '0;
                    oh <= 1'b0;
`ifdef DB_PARITY_EN
                    op <= 1'b0;
`endif
                end else begin
                    od <= data;
                    oh <= hit;
`ifdef DB_PARITY_EN
                    op <= perr_c[i];
`endif
                end
            end
        end
        assign rd_data[i*W +: W] = od;
        assign rd_hit[i]         = oh;
    end

    assign err_set = (wr_acc && !({1'b0, wr_addr} < LIM)) || |rd_oor || |perr_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            addr_err <= 1'b0;
        else if (err_set)
            addr_err <= 1'b1;
        else if (err_clr)
            addr_err <= 1'b0;
    end
endmodule

// File: tb/tb_data_bank_mp.sv
// tb_data_bank_mp: self-checking bench, combinational/forwarding and registered/no-forward instances on shared stimulus.
module tb_data_bank_mp;
    logic        clk;
    logic        rst_n;
    logic        clr_req;
    logic        wr_valid;
    logic [5:0]  wr_addr;
    logic [23:0] wr_data;
    logic [11:0] rd_addr;
    logic        err_clr;
    logic        busy0, wr_ready0, addr_err0;
    logic        busy1, wr_ready1, addr_err1;
    logic [47:0] rd_data0, rd_data1;
    logic [1:0]  rd_hit0, rd_hit1;
`ifdef DB_PARITY_EN
    logic [1:0]  rd_perr0, rd_perr1;
`endif

    int cmp_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic        we;
        logic [5:0]  wa;
        logic [23:0] wd;
        logic [5:0]  r0;
        logic [5:0]  r1;
        logic [23:0] x0;
        logic        h0;
        logic [23:0] x1;
        logic        h1;
        logic [23:0] y;
        logic        g;
    } vec_t;

    typedef struct {
        logic [23:0] d;
        logic        h;
    } exp_t;

    vec_t tv [9];
    exp_t q [$];
    exp_t e;
    int   n;

    data_bank_mp #(.W(24), .DEPTH(40), .ADDRW(6), .NRD(2), .RD_LAT(0), .FORWARD(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy0),
        .wr_valid(wr_valid), .wr_ready(wr_ready0), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data0), .rd_hit(rd_hit0), .addr_err(addr_err0),
`ifdef DB_PARITY_EN
        .rd_perr(rd_perr0),
`endif
        .err_clr(err_clr)
    );

    data_bank_mp #(.W(24), .DEPTH(40), .ADDRW(6), .NRD(2), .RD_LAT(1), .FORWARD(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy1),
        .wr_valid(wr_valid), .wr_ready(wr_ready1), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data1), .rd_hit(rd_hit1), .addr_err(addr_err1),
`ifdef DB_PARITY_EN
        .rd_perr(rd_perr1),
`endif
        .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s act=0x%0h exp=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at a negedge; counts negedges with busy high, optionally re-pulsing clr_req mid-sweep.
    task automatic count_busy(output int cnt, input int reissue);
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (!busy0) break;
            cnt++;
            chk("sweep_wr_ready", {31'd0, wr_ready0}, 32'd0);
            chk("sweep_hit", {30'd0, rd_hit0}, 32'd0);
            clr_req = (cnt == reissue);
            @(negedge clk);
        end
        clr_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clr_req = 1'b0; wr_valid = 1'b0; wr_addr = '0;
        wr_data = '0; rd_addr = '0; err_clr = 1'b0;
        tv[0] = '{1'b0, 6'd0,  24'h0,      6'd3,  6'd39, 24'h0,      1'b0, 24'h0,      1'b0, 24'h0,      1'b0};
        tv[1] = '{1'b1, 6'd5,  24'hABCDEF, 6'd5,  6'd6,  24'hABCDEF, 1'b1, 24'h0,      1'b0, 24'h0,      1'b0};
        tv[2] = '{1'b0, 6'd0,  24'h0,      6'd5,  6'd5,  24'hABCDEF, 1'b1, 24'hABCDEF, 1'b1, 24'hABCDEF, 1'b1};
        tv[3] = '{1'b1, 6'd7,  24'h000123, 6'd7,  6'd5,  24'h000123, 1'b1, 24'hABCDEF, 1'b1, 24'h0,      1'b0};
        tv[4] = '{1'b1, 6'd5,  24'h555555, 6'd5,  6'd7,  24'h555555, 1'b1, 24'h000123, 1'b1, 24'hABCDEF, 1'b1};
        tv[5] = '{1'b0, 6'd0,  24'h0,      6'd5,  6'd39, 24'h555555, 1'b1, 24'h0,      1'b0, 24'h555555, 1'b1};
        tv[6] = '{1'b1, 6'd39, 24'hFFFFFF, 6'd39, 6'd0,  24'hFFFFFF, 1'b1, 24'h0,      1'b0, 24'h0,      1'b0};
        tv[7] = '{1'b0, 6'd0,  24'h0,      6'd39, 6'd7,  24'hFFFFFF, 1'b1, 24'h000123, 1'b1, 24'hFFFFFF, 1'b1};
        tv[8] = '{1'b0, 6'd0,  24'h0,      6'd0,  6'd0,  24'h0,      1'b0, 24'h0,      1'b0, 24'h0,      1'b0};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", {31'd0, busy0}, 32'd1);
        chk("rst_wr_ready", {31'd0, wr_ready0}, 32'd0);
        chk("rst_addr_err", {31'd0, addr_err0}, 32'd0);
        chk("rst_rdreg_data", rd_data1[31:0], 32'd0);
        chk("rst_rdreg_hit", {30'd0, rd_hit1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(n, -1);
        chk("reset_sweep_len", n, 32'd40);

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            wr_valid = tv[i].we; wr_addr = tv[i].wa; wr_data = tv[i].wd;
            rd_addr  = {tv[i].r1, tv[i].r0};
            #1;
            chk($sformatf("v%0d_p0_data", i), {8'd0, rd_data0[23:0]}, {8'd0, tv[i].x0});
            chk($sformatf("v%0d_p0_hit", i), {31'd0, rd_hit0[0]}, {31'd0, tv[i].h0});
            chk($sformatf("v%0d_p1_data", i), {8'd0, rd_data0[47:24]}, {8'd0, tv[i].x1});
            chk($sformatf("v%0d_p1_hit", i), {31'd0, rd_hit0[1]}, {31'd0, tv[i].h1});
            if (q.size() > 0) begin
                e = q.pop_front();
                chk($sformatf("v%0d_reg_data", i - 1), {8'd0, rd_data1[23:0]}, {8'd0, e.d});
                chk($sformatf("v%0d_reg_hit", i - 1), {31'd0, rd_hit1[0]}, {31'd0, e.h});
            end
            q.push_back('{tv[i].y, tv[i].g});
        end
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        e = q.pop_front();
        chk("v8_reg_data", {8'd0, rd_data1[23:0]}, {8'd0, e.d});
        chk("v8_reg_hit", {31'd0, rd_hit1[0]}, {31'd0, e.h});

        // registered ports reading the same freshly written address
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 6'd8; wr_data = 24'h000456; rd_addr = {6'd0, 6'd0};
        @(negedge clk);
        wr_valid = 1'b0; rd_addr = {6'd8, 6'd8};
        #1;
        chk("dual_comb", {8'd0, rd_data0[47:24] ^ rd_data0[23:0]}, 32'd0);
        chk("dual_comb_p0", {8'd0, rd_data0[23:0]}, 32'h000456);
        @(negedge clk);
        #1;
        chk("dual_reg_p0", {8'd0, rd_data1[23:0]}, 32'h000456);
        chk("dual_reg_p1", {8'd0, rd_data1[47:24]}, 32'h000456);
        chk("dual_reg_hit", {30'd0, rd_hit1}, 32'd3);

        // out-of-range write, sticky error, clear, read error, clear-vs-set priority
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 6'd45; wr_data = 24'h777777; rd_addr = {6'd13, 6'd5};
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        chk("oor_wr_err", {31'd0, addr_err0}, 32'd1);
        chk("oor_wr_keep5", {8'd0, rd_data0[23:0]}, 32'h555555);
        chk("oor_wr_alias13", {31'd0, rd_hit0[1]}, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("oor_sticky", {31'd0, addr_err0}, 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        chk("err_clr", {31'd0, addr_err0}, 32'd0);
        rd_addr = {6'd5, 6'd50};
        #1;
        chk("oor_rd_data", {8'd0, rd_data0[23:0]}, 32'd0);
        chk("oor_rd_hit", {31'd0, rd_hit0[0]}, 32'd0);
        @(negedge clk);
        err_clr = 1'b1;
        #1;
        chk("oor_rd_err", {31'd0, addr_err0}, 32'd1);
        chk("oor_rd_reg", {7'd0, rd_hit1[0], rd_data1[23:0]}, 32'd0);
        @(negedge clk);
        rd_addr = {6'd7, 6'd5};
        #1;
        chk("err_set_wins", {31'd0, addr_err1}, 32'd1);
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        chk("err_clr2", {31'd0, addr_err0}, 32'd0);

        // software clear with a re-request and blocked writes mid-sweep
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        wr_valid = 1'b1; wr_addr = 6'd45; wr_data = 24'h123456;
        count_busy(n, 10);
        wr_valid = 1'b0;
        chk("clr_sweep_len", n, 32'd40);
        chk("busy_wr_no_err", {31'd0, addr_err0}, 32'd0);
        rd_addr = {6'd7, 6'd5};
        #1;
        chk("clr_zero_5_7", {8'd0, rd_data0[23:0] | rd_data0[47:24]}, 32'd0);
        chk("clr_hit_5_7", {30'd0, rd_hit0}, 32'd0);
        rd_addr = {6'd39, 6'd8};
        #1;
        chk("clr_zero_8_39", {8'd0, rd_data0[23:0] | rd_data0[47:24]}, 32'd0);
        chk("clr_hit_8_39", {30'd0, rd_hit0}, 32'd0);

        // reset in the middle of a sweep restarts it
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy0}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(n, -1);
        chk("midrst_sweep_len", n, 32'd40);

`ifdef DB_PARITY_EN
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 6'd3; wr_data = 24'h0F0F0F; rd_addr = {6'd0, 6'd0};
        @(negedge clk);
        wr_valid = 1'b0;
        dut0.mem[3] = dut0.mem[3] ^ 25'd1;
        rd_addr = {6'd0, 6'd3};
        #1;
        chk("perr_flag", {31'd0, rd_perr0[0]}, 32'd1);
        @(negedge clk);
        #1;
        chk("perr_err", {31'd0, addr_err0}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
